// File: rtl/expr_recognizer_if.sv
// Character-stream interface for expr_recognizer: per-cycle character input
// with restart, and the registered recognition status coming back.
interface expr_recognizer_if #(
    parameter int DW = 3
) ();
    logic          restart;
    logic          in_valid;
    logic [7:0]    in;
    logic          out;
    logic          err;
    logic [DW-1:0] depth;

    modport master (
        output restart, in_valid, in,
        input  out, err, depth
    );

    modport slave (
        input  restart, in_valid, in,
        output out, err, depth
    );
endinterface : expr_recognizer_if

// File: rtl/expr_recognizer.sv
// Streaming recognizer for arithmetic expressions built from bounded-length
// numbers, +/-/(optional *) operators and bounded-depth parentheses.
module expr_recognizer #(
    parameter int MAX_DIGITS = 4,
    parameter int MAX_DEPTH  = 7,
    parameter bit MUL_EN     = 1'b1
) (
    input  logic              clk,
    input  logic              clr,
    expr_recognizer_if.slave  bus
);
    localparam int DW = $clog2(MAX_DEPTH + 1);
    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam logic [DW-1:0] DEPTH_MAX = DW'(MAX_DEPTH);
    localparam logic [CW-1:0] DIGIT_MAX = CW'(MAX_DIGITS);

    typedef enum logic [2:0] {
        S_START,
        S_OPND,
        S_NUM,
        S_CLOSE,
        S_ERR
    } state_e;

    typedef enum logic [2:0] {
        C_DIG,
        C_OP,
        C_LP,
        C_RP,
        C_SP,
        C_ILL
    } class_e;

    function automatic class_e classify(input logic [7:0] ch);
        if (ch >= "0" && ch <= "9")            return C_DIG;
        else if (ch == "+" || ch == "-")       return C_OP;
        else if (ch == "*" && MUL_EN)          return C_OP;
        else if (ch == "(")                    return C_LP;
        else if (ch == ")")                    return C_RP;
        else if (ch == 8'h20)                  return C_SP;
        else                                   return C_ILL;
    endfunction

    state_e        state_q, state_d;
    logic [DW-1:0] depth_q, depth_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          out_q,   out_d;
    logic          err_q,   err_d;
    class_e        cls;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d = state_q;
        depth_d = depth_q;
        cnt_d   = cnt_q;
        cls     = classify(bus.in);

        if (bus.restart) begin
            state_d = S_START;
            depth_d = '0;
            cnt_d   = '0;
        end else if (bus.in_valid && state_q != S_ERR && cls != C_SP) begin
            // Error transitions leave depth and digit count at their pre-error values.
            unique case (state_q)
                S_START, S_OPND: begin
                    if (cls == C_DIG) begin
                        state_d = S_NUM;
                        cnt_d   = CW'(1);
                    end else if (cls == C_LP && depth_q < DEPTH_MAX) begin
                        state_d = S_OPND;
                        depth_d = depth_q + DW'(1);
                    end else begin
                        state_d = S_ERR;
                    end
                end
                S_NUM: begin
                    if (cls == C_DIG && cnt_q < DIGIT_MAX) begin
                        cnt_d = cnt_q + CW'(1);
                    end else if (cls == C_OP) begin
                        state_d = S_OPND;
                    end else if (cls == C_RP && depth_q != '0) begin
                        state_d = S_CLOSE;
                        depth_d = depth_q - DW'(1);
                    end else begin
                        state_d = S_ERR;
                    end
                end
                S_CLOSE: begin
                    if (cls == C_OP) begin
                        state_d = S_OPND;
                    end else if (cls == C_RP && depth_q != '0) begin
                        depth_d = depth_q - DW'(1);
                    end else begin
                        state_d = S_ERR;
                    end
                end
                default: state_d = S_ERR;
            endcase
        end

        out_d = (state_d == S_NUM || state_d == S_CLOSE) && depth_d == '0;
        err_d = (state_d == S_ERR);
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_START;
            depth_q <= '0;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            depth_q <= depth_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            err_q   <= err_d;
        end
    end

    assign bus.out   = out_q;
    assign bus.err   = err_q;
    assign bus.depth = depth_q;

endmodule : expr_recognizer

// File: doc/expr_recognizer.md
EXPR_RECOGNIZER -- requirements
Module: expr_recognizer

Interface
REQ-001 Parameter MAX_DIGITS, default 4, SHALL set the maximum digit count of one number literal (legal range 1..15).
REQ-002 Parameter MAX_DEPTH, default 7, SHALL set the maximum parenthesis nesting depth (legal range 1..15).
REQ-003 Parameter MUL_EN, default 1, SHALL make '*' a legal operator when 1; when 0, '*' SHALL be an illegal character.
REQ-004 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 clr  input  1  SHALL be an asynchronous, active-low reset.
REQ-006 restart  input  1  SHALL be a synchronous request to begin a new expression.
REQ-007 in_valid  input  1  SHALL qualify in; the character is consumed only on an edge where in_valid=1.
REQ-008 in  input  8  SHALL carry one ASCII character.
REQ-009 out  output  1  SHALL be high when the characters consumed so far form a complete, valid expression.
REQ-010 err  output  1  SHALL be a sticky error flag.
REQ-011 depth  output  DW  SHALL give the current open-parenthesis count, where DW = $clog2(MAX_DEPTH+1).

Function
REQ-012 Character classes SHALL be:
- DIG = '0'..'9'.
- OP = '+', '-', plus '*' when MUL_EN=1.
- LP = '('.
- RP = ')'.
- SP = 8'h20.
- ILL = any other value.
REQ-013 The FSM states SHALL be START, OPND (expecting an operand), NUM (inside a number), CLOSE (after ')'), and ERR.
REQ-014 SP SHALL be ignored in every state, with no state or counter change; consequently "12 3" SHALL be treated as the number 123.
REQ-015 START and OPND SHALL both transition as follows:
- DIG -> NUM, with the digit count set to 1.
- LP -> OPND with depth+1 if depth<MAX_DEPTH, otherwise -> ERR.
- OP, RP or ILL -> ERR.
REQ-016 NUM SHALL transition as follows:
- DIG -> NUM with digit count+1 if count<MAX_DIGITS, otherwise -> ERR.
- OP -> OPND.
- RP -> CLOSE with depth-1 if depth>0, otherwise -> ERR.
- LP or ILL -> ERR.
REQ-017 CLOSE SHALL transition as follows:
- OP -> OPND.
- RP -> CLOSE with depth-1 if depth>0, otherwise -> ERR.
- DIG, LP or ILL -> ERR.
REQ-018 ERR SHALL hold regardless of in or in_valid until restart or reset.
REQ-019 out SHALL be registered and SHALL equal 1 exactly when the state is NUM or CLOSE and depth==0.
REQ-020 out SHALL therefore become valid on the same edge that consumes the deciding character, i.e. one-cycle latency from the input sample.
REQ-021 err SHALL be 1 exactly when the state is ERR; out SHALL be 0 whenever err=1.
REQ-022 restart=1 SHALL, on the next edge, set the state to START, depth to 0, the digit count to 0, out to 0 and err to 0.
REQ-023 restart SHALL take priority over in_valid; the character presented on a restart edge SHALL be discarded.
REQ-024 When in_valid=0 and restart=0, all registers SHALL hold their values.
REQ-025 depth SHALL never exceed MAX_DEPTH and SHALL never wrap below 0; both boundaries SHALL resolve to ERR as specified, with depth held at its pre-error value.
REQ-026 The digit counter SHALL saturate at MAX_DIGITS; an overflowing digit SHALL go to ERR and SHALL NOT wrap the counter.

Reset
REQ-027 While clr=0, the block SHALL asynchronously force: state=START, depth=0, digit count=0, out=0, err=0.
REQ-028 Deassertion of clr SHALL take effect on the next rising clk edge.
REQ-029 Assertion of clr mid-expression SHALL discard all progress; no partial state SHALL survive.

Verification
REQ-030 Stimulus: after reset, stream "1","+","+","1" with in_valid=1 each cycle.
- Required out: 1,0,0,0.
- Required err: 0,0,1,1.
- err SHALL stay 1 until restart.
REQ-031 Stimulus: "(","1","2","*","3",")","-","4".
- Required depth: 1,1,1,1,1,0,0,0.
- Required out: 0,0,0,0,0,1,0,1.
- Required err: 0 throughout.
REQ-032 Stimulus: MAX_DEPTH=2, stream "(","(","(".
- Required: err=1 on the third edge, with depth=2.
- Stimulus continues: ")" -> state SHALL remain ERR.
REQ-033 Stimulus: MAX_DIGITS=4, stream "12345".
- Required out: 1,1,1,1,0.
- Required err: 1 only on the fifth edge.
- Stimulus continues: restart=1 together with in="7" -> out=0, err=0, depth=0, and the "7" SHALL be ignored.
REQ-034 Stimulus: MUL_EN=0, stream "2","*".
- Required: err=1 on the second edge.
- Separately: "3",")" -> err=1, with depth held at 0.
REQ-035 Stimulus: mid-stream of "(1+", drive clr low for 7 ns between clock edges.
- Required: out, err and depth SHALL read 0 immediately.
- Required: after clr returns high, "5" SHALL give out=1.
